// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and instruction memory.
// The fetch unit is the master; the memory model or SRAM wrapper is the slave.
interface instr_fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        valid;

    modport master (
        output req,
        output addr,
        input  rdata,
        input  valid
    );

    modport slave (
        input  req,
        input  addr,
        output rdata,
        output valid
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word per instruction over the imem handshake,
// presents it to the decoder and commits the next PC (sequential/branch/jump) on exec_done.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic               clk,
    input  logic               rst,
    instr_fetch_unit_if.master imem,
    output logic [31:0]        instr,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               branch,
    input  logic               zero,
    input  logic               jump,
    output logic [31:0]        pc,
    output logic [31:0]        pc_plus4,
    output logic               fetch_err
);

    localparam int unsigned WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [31:0]       pc_r;
    logic [31:0]       pc_s;
    logic [31:0]       instr_r;
    logic [31:0]       instr_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [WAIT_W-1:0] wait_cnt_s;
    logic [31:0]       pc_plus4_s;
    logic [31:0]       br_off_s;
    logic [31:0]       next_pc_s;

    // Sequential successor, branch displacement and the prioritised next-PC selection
    always_comb begin
        pc_plus4_s = pc_r + 32'd4;
        br_off_s   = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
        next_pc_s  = pc_plus4_s;
        if (jump) begin
            next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
        end else if (branch && zero) begin
            next_pc_s = pc_plus4_s + br_off_s;
        end else begin
            next_pc_s = pc_plus4_s;
        end
    end

    // Next-state logic; branch/jump only reach state through the exec_done path
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        instr_s    = instr_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.valid) begin
                    instr_s    = imem.rdata;
                    wait_cnt_s = {WAIT_W{1'b0}};
                    state_s    = ST_ISSUE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                    state_s    = ST_ERROR;
                end else begin
                    wait_cnt_s = wait_cnt_r + WAIT_W'(1);
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    pc_s    = next_pc_s;
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            pc_r       <= RESET_PC;
            instr_r    <= 32'h0000_0000;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            instr_r    <= instr_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    assign imem.req    = (state_r == ST_FETCH);
    assign imem.addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[31:26];
    assign funct       = instr_r[5:0];
    assign instr_valid = (state_r == ST_ISSUE);
    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign fetch_err   = (state_r == ST_ERROR);

endmodule
